// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, runs a 32-step restoring
// divider and a multi-cycle multiply, and stalls the pipeline only when needed.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // 32 restoring iterations plus one sign-fixup cycle; the divider relies on this.
  localparam int DIV_CYCLES = 33;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [5:0]  counter;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] res_q;

  logic [3:0]  op_eff;
  logic        op_is_div;
  logic        op_is_mul;
  logic        accept;

  assign op_eff    = (mdu_op_i > OP_MTLO) ? OP_NONE : mdu_op_i;
  assign op_is_div = (op_eff == OP_DIV) || (op_eff == OP_DIVU);
  assign op_is_mul = (op_eff == OP_MUL) || (op_eff == OP_MULT) || (op_eff == OP_MULTU);
  assign accept    = (state == ST_IDLE) && (op_is_div || op_is_mul) && !flush_i;

  // Multiply: sign- or zero-extend the latched operands, keep the low 64 bits.
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;

  assign mul_a_ext = (op_q == OP_MULTU) ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
  assign mul_b_ext = (op_q == OP_MULTU) ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // Restoring divide step on magnitudes; div_quo shifts the dividend out as quotient bits enter.
  logic        div_signed;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        rem_take;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  assign div_signed = (op_q == OP_DIV);
  assign b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
  assign rem_shift  = {div_rem, div_quo[31]};
  assign rem_sub    = rem_shift - {1'b0, b_mag};
  assign rem_take   = !rem_sub[32];

  always_comb begin
    quo_final = (div_signed && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
    rem_final = (div_signed && a_q[31]) ? -div_rem : div_rem;
    if (b_q == 32'd0) begin
      quo_final = 32'hFFFF_FFFF;
      rem_final = a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      div_rem <= 32'd0;
      div_quo <= 32'd0;
      counter <= 6'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_eff;
            a_q     <= a_i;
            b_q     <= b_i;
            div_rem <= 32'd0;
            div_quo <= (op_eff == OP_DIV && a_i[31]) ? -a_i : a_i;
            counter <= op_is_div ? 6'(DIV_CYCLES) : 6'(MUL_CYCLES);
            state   <= ST_BUSY;
          end else if (!flush_i) begin
            if (op_eff == OP_MTHI) hi <= a_i;
            if (op_eff == OP_MTLO) lo <= a_i;
          end
        end
        ST_BUSY: begin
          counter <= counter - 6'd1;
          if (counter == 6'd1) begin
            state <= ST_IDLE;
            case (op_q)
              OP_MULT, OP_MULTU: begin
                hi <= product[63:32];
                lo <= product[31:0];
              end
              OP_DIV, OP_DIVU: begin
                hi <= rem_final;
                lo <= quo_final;
              end
              default: begin
                res_q <= product[31:0];
                state <= ST_DONE;
              end
            endcase
          end else if (op_q == OP_DIV || op_q == OP_DIVU) begin
            div_rem <= rem_take ? rem_sub[31:0] : rem_shift[31:0];
            div_quo <= {div_quo[30:0], rem_take};
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    result_o = 32'd0;
    if (state == ST_DONE) begin
      result_o = res_q;
    end else if (state == ST_IDLE) begin
      if (op_eff == OP_MFHI) result_o = hi;
      if (op_eff == OP_MFLO) result_o = lo;
    end
  end

  assign stall_o = ((state == ST_IDLE) && (op_eff == OP_MUL) && !flush_i) ||
                   ((state == ST_BUSY) && (op_eff != OP_NONE));
  assign busy_o  = (state != ST_IDLE);
  assign hi_o    = hi;
  assign lo_o    = lo;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit (MDU), with ownership of the HI/LO register pair.
- Consumes the 4-bit mdu_op code produced by instruction decode and runs iterative divide and multi-cycle multiply.
- Raises a pipeline stall only when an instruction needs an MDU result, or the MDU itself, while an operation is in flight.
- MULT/MULTU/DIV/DIVU issue non-blocking; MUL blocks until its GPR result is ready.

Parameters:
- MUL_CYCLES, 3, number of BUSY cycles for any multiply (legal 1..15).
- DIV_CYCLES, 33, BUSY cycles for divide: 32 restoring iterations plus 1 sign-fixup cycle (fixed; not to be overridden).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- mdu_op_i  in  4  0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO, 10-15 treated as 0.
- a_i  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b_i  in  32  rt operand (divisor / multiplier).
- flush_i  in  1  the instruction in ID is being killed (exception/interrupt); suppresses acceptance.
- result_o  out  32  GPR result for MUL/MFHI/MFLO.
- stall_o  out  1  freeze fetch/ID; combinational.
- busy_o  out  1  state != IDLE.
- hi_o  out  32  architectural HI.
- lo_o  out  32  architectural LO.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi, lo, res_q, counter, operand regs = 0.
  - busy_o=0.
  - stall_o follows its equation with state=IDLE.
- States: IDLE, BUSY, DONE.
- Accept: a cycle with state=IDLE, op in {1,2,3,4,5} and flush_i=0.
  - Latch a_i, b_i, op.
  - Load counter with MUL_CYCLES (ops 3,4,5) or DIV_CYCLES (ops 1,2).
  - Next state = BUSY.
- BUSY: counter decrements each cycle.
  - On the edge ending the cycle where counter==1:
    - ops 4/5: HI/LO <= 64-bit product, then go to IDLE.
    - ops 1/2: LO <= quotient, HI <= remainder, then go to IDLE.
    - op 3: res_q <= product[31:0] (HI/LO unchanged), then go to DONE.
  - Busy window is cycles 1..N after the accept edge. HI/LO become visible in cycle N+1.
- DONE (MUL only): one cycle.
  - result_o=res_q, stall_o=0.
  - The pipeline advances and the MUL retires.
  - Next state = IDLE. The held op 3 is not re-accepted.
- stall_o = (state==IDLE && op==3 && !flush_i) || (state==BUSY && op in 1..9).
  - Any MDU op arriving during BUSY waits.
  - The pipeline holds mdu_op_i, a_i and b_i stable while stall_o=1.
- In IDLE, single-cycle ops (no stall):
  - MFHI: result_o=hi, combinational.
  - MFLO: result_o=lo, combinational.
  - MTHI: hi <= a_i at the edge.
  - MTLO: lo <= a_i at the edge.
  - result_o=0 for all other ops/states.
- Multiply arithmetic:
  - ops 3/4: signed 32x32.
  - op 5: unsigned.
  - Full 64-bit product; MUL keeps bits [31:0].
- Divide arithmetic:
  - DIVU: unsigned restoring divide, 1 quotient bit per cycle for 32 cycles, then 1 idle fixup cycle.
  - DIV: divide magnitudes. Fixup cycle negates the quotient if a[31]^b[31], and negates the remainder if a[31].
  - Remainder sign follows the dividend.
- Divide boundary cases:
  - Divisor 0 (DIV or DIVU): LO=32'hFFFFFFFF, HI=a; no exception; full 33 cycles still taken.
  - DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- flush_i:
  - In IDLE it blocks acceptance and MTHI/MTLO writes.
  - During BUSY/DONE it is ignored: the in-flight operation belongs to an older, committed instruction and completes.
- Reset mid-operation aborts immediately: state IDLE, HI/LO=0.
- Back-to-back ops:
  - An op held during BUSY is accepted in the first IDLE cycle.
  - MULT immediately followed by MFLO: MFLO stalls N cycles, then reads the new LO.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, then MFHI/MFLO next -> stall_o=1 for 3 cycles, then HI=0xFFFFFFFE, LO=0x00000001, result_o matches.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MUL a=-3, b=5 -> stall_o high in accept cycle plus 3 BUSY cycles, DONE cycle result_o=0xFFFFFFF1, HI/LO unchanged.
- MULT with flush_i=1 in IDLE -> no accept, busy_o stays 0, HI/LO unchanged. MTLO 0xA5A5A5A5 with flush_i=0 -> lo_o=0xA5A5A5A5 next cycle.
- rst_n pulled low at DIV BUSY cycle 10 -> asynchronous return to IDLE, hi_o=lo_o=0, busy_o=0. Next DIVU after release completes correctly.
